// File: rtl/cmd_mem_reader.sv
// cmd_mem_reader: scans the command memory, dispatches due commands to the sequencer,
// then asks the writer to erase the slot. Optional late-command drop: CMD_LATE_DROP_EN.
module cmd_mem_reader #(
  parameter int unsigned N_IDX     = 255,
  parameter logic [63:0] TIME_LEAD = 64'd16
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [63:0]   SYS_TIME,
  input  logic          WR_BUSY,
  output logic [7:0]    rd_addr,
  output logic          rd_en,
  input  logic [337:0]  rd_data,
  output logic          clr_req,
  output logic [7:0]    clr_addr,
  input  logic          clr_ack,
  output logic          CMD_VALID,
  input  logic          CMD_READY,
  output logic [7:0]    CMD_ADDR,
  output logic [47:0]   FREQ,
  output logic [47:0]   FREQ_STEP,
  output logic [31:0]   FREQ_RATE,
  output logic [63:0]   TIME_START,
  output logic [15:0]   N_impulse,
  output logic [1:0]    TYPE_impulse,
  output logic [31:0]   Interval_Ti,
  output logic [31:0]   Interval_Tp,
  output logic [31:0]   Tblank1,
  output logic [31:0]   Tblank2,
  output logic          SCAN_DONE,
  output logic [15:0]   LATE_CNT
);

  localparam int unsigned AW       = 8;
  localparam logic [63:0] EMPTY_TS = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {IDLE, READ, EVAL, OUT, CLR} state_t;
  state_t state;

  logic [63:0] w_ts;
  logic [47:0] w_freq, w_fstep;
  logic [31:0] w_frate, w_ti, w_tp, w_tb1, w_tb2;
  logic [15:0] w_nimp;
  logic [1:0]  w_type;
  logic        empty_w, due_w, late_w, wrap_w, advance_w;

  assign {w_ts, w_freq, w_fstep, w_frate, w_nimp, w_type, w_ti, w_tp, w_tb1, w_tb2} = rd_data;

  assign empty_w = (w_ts == EMPTY_TS);
  assign due_w   = (w_ts <= (SYS_TIME + TIME_LEAD));
`ifdef CMD_LATE_DROP_EN
  assign late_w  = !empty_w && (w_ts < SYS_TIME);
`else
  assign late_w  = 1'b0;
  assign LATE_CNT = 16'd0;
`endif
  assign wrap_w    = (rd_addr == AW'(N_IDX));
  // Move to the next slot after a skipped evaluation or an acknowledged clear
  assign advance_w = ((state == EVAL) && !late_w && (empty_w || !due_w)) ||
                     ((state == CLR) && clr_ack);

  // rd_addr doubles as the scan address; it only moves on advance
  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      rd_addr      <= '0;
      rd_en        <= 1'b0;
      clr_req      <= 1'b0;
      clr_addr     <= '0;
      CMD_VALID    <= 1'b0;
      CMD_ADDR     <= '0;
      FREQ         <= '0;
      FREQ_STEP    <= '0;
      FREQ_RATE    <= '0;
      TIME_START   <= '0;
      N_impulse    <= '0;
      TYPE_impulse <= '0;
      Interval_Ti  <= '0;
      Interval_Tp  <= '0;
      Tblank1      <= '0;
      Tblank2      <= '0;
      SCAN_DONE    <= 1'b0;
`ifdef CMD_LATE_DROP_EN
      LATE_CNT     <= '0;
`endif
    end else begin
      rd_en     <= 1'b0;
      SCAN_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (!WR_BUSY) begin
            rd_en <= 1'b1;
            state <= READ;
          end
        end
        READ: state <= EVAL;
        EVAL: begin
          if (late_w) begin
            clr_req  <= 1'b1;
            clr_addr <= rd_addr;
            state    <= CLR;
`ifdef CMD_LATE_DROP_EN
            if (LATE_CNT != 16'hFFFF) LATE_CNT <= LATE_CNT + 16'd1;
`endif
          end else if (!empty_w && due_w) begin
            TIME_START   <= w_ts;
            FREQ         <= w_freq;
            FREQ_STEP    <= w_fstep;
            FREQ_RATE    <= w_frate;
            N_impulse    <= w_nimp;
            TYPE_impulse <= w_type;
            Interval_Ti  <= w_ti;
            Interval_Tp  <= w_tp;
            Tblank1      <= w_tb1;
            Tblank2      <= w_tb2;
            CMD_ADDR     <= rd_addr;
            CMD_VALID    <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (CMD_READY) begin
            CMD_VALID <= 1'b0;
            clr_req   <= 1'b1;
            clr_addr  <= CMD_ADDR;
            state     <= CLR;
          end
        end
        CLR: begin
          if (clr_ack) clr_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (advance_w) begin
        rd_addr   <= wrap_w ? '0 : rd_addr + AW'(1);
        SCAN_DONE <= wrap_w;
        if (WR_BUSY) begin
          state <= IDLE;
        end else begin
          rd_en <= 1'b1;
          state <= READ;
        end
      end
    end
  end

endmodule
